vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Framebuffer access controller between the VGA timing generator and a single-port 32×24-cell color RAM (one 8-bit color per 20×20-pixel cell). It prefetches each cell's color one cell ahead of the beam and drives `colorPacking` to the timing generator. It shares the remaining RAM cycles with one writer over a valid/ready handshake. An optional engine fills the whole framebuffer with one color.

## Interface
Parameters:
- `CELL_PX`, default 20: cell edge in pixels.
- `COLS`, default 32: cells per row.
- `ROWS`, default 24: cell rows.
- `HTOTAL`, default 800: horizontal count per line.
- `VTOTAL`, default 525: lines per frame.

Ports:
- `vgaclk` in, 1: pixel clock, the only clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `hc` in, 10: horizontal counter from the timing generator.
- `vc` in, 10: vertical counter from the timing generator.
- `colorPacking` out, 8: color for the current pixel.
- `wr_valid` in, 1: writer request.
- `wr_ready` out, 1: controller can accept the write this cycle.
- `wr_addr` in, 10: cell index, row*COLS+col.
- `wr_data` in, 8: color to write.
- `wr_err` out, 1: one-cycle pulse when an accepted write has an address ≥ COLS*ROWS.
- `clr_req` in, 1: start a fill (VGA_FB_CLEAR_EN only).
- `clr_color` in, 8: fill color.
- `clr_busy` out, 1: fill in progress.
- `clr_done` out, 1: one-cycle pulse when the fill completes.
- `mem_addr` out, 10: RAM address.
- `mem_we` out, 1: RAM write enable.
- `mem_wdata` out, 8: RAM write data.
- `mem_rdata` in, 8: RAM read data, one-cycle synchronous read.

## Operation
- **Display slot.** The slot is the cycle in which a display read owns the RAM. It occurs when either:
  - (hc%CELL_PX)==CELL_PX-2, hc<COLS*CELL_PX-2, and vc<ROWS*CELL_PX. Address = (vc/CELL_PX)*COLS+(hc+2)/CELL_PX.
  - hc==HTOTAL-2 and nv<ROWS*CELL_PX, where nv = (vc==VTOTAL-1)?0:vc+1. Address = (nv/CELL_PX)*COLS.
- **Slot drive.** In a slot: mem_we=0 and mem_addr=fetch address. Set a one-bit pending flag. On the next edge, load mem_rdata into `colorPacking`.
- **Hold.** `colorPacking` holds its value outside fetches. Blanking is handled by the timing generator.
- **Writer handshake.**
  - wr_ready = !slot && state==IDLE && rst_n, combinational.
  - A transfer occurs in the cycle with wr_valid&&wr_ready.
  - In that cycle: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, all combinational.
  - If wr_addr≥COLS*ROWS: mem_we=0 and wr_err pulses on the next cycle.
  - The writer must hold its request stable until ready.
- **Idle RAM port.** With no transfer and no slot: mem_we=0, mem_addr=0.
- **Fill FSM** (VGA_FB_CLEAR_EN), states IDLE and CLEAR:
  - IDLE→CLEAR when clr_req=1. Latch clr_color, set clr_addr=0, assert clr_busy.
  - In CLEAR, each non-slot cycle writes the latched color to clr_addr, then increments clr_addr.
  - After address COLS*ROWS-1 is written: go to IDLE, pulse clr_done, drop clr_busy.
  - clr_req is ignored while in CLEAR. The writer is stalled for the whole fill.
- **Priority.** Display slot > fill > writer.

## Timing
- **Reset values.** colorPacking=0, wr_err=0, clr_busy=0, clr_done=0, mem_we=0, mem_addr=0, state=IDLE, pending=0.
- **Fetch pipeline.**
  - Address presented at hc=s-2.
  - RAM samples it on that cycle's edge; rdata is valid during hc=s-1.
  - colorPacking updates on the edge into hc=s, where s is the cell start.
  - Total latency: two cycles.
- **Line and frame wrap.** The first cell of a line is fetched at hc=HTOTAL-2 of the previous line. At vc=VTOTAL-1 this fetches row 0.
- **Writer latency.** A write is visible to display fetches issued from the next cycle on. A write to the cell currently on screen takes effect at that cell's next fetch.
- **Reset mid-fill.** Returns to IDLE; the RAM is left partially filled and no clr_done pulse is produced.
- **Fill duration.** COLS*ROWS non-slot cycles.

## Configuration
- **`VGA_FB_CLEAR_EN` defined.** Fill FSM and clr_addr counter are present.
- **`VGA_FB_CLEAR_EN` undefined.**
  - clr_req and clr_color are ignored.
  - clr_busy=0 and clr_done=0 permanently.
  - State is always IDLE.

## Structure
- **Package `vga_pkg`.** Holds the timing constants (HPIXELS 640, HFP 16, HSPULSE 96, HBP 48, VPIXELS 480, VFP 10, VSPULSE 2, VBP 33), the CELL_PX/COLS/ROWS defaults, FB_DEPTH=768, and the `fb_state_t` enum {IDLE, CLEAR}.
- **Sub-module `vga_fb_slot`.** Combinational slot decode and fetch-address generation from hc/vc.
- **Top.** Owns the arbitration, pipeline registers and fill FSM.

## Test plan
- **Reset.** Hold rst_n=0 with random inputs → all outputs at reset values and wr_ready=0. Release at hc=5 → wr_ready=1.
- **Write then display.** Write addr 33, data 0xA5 at vc=500, then run the frame → colorPacking==0xA5 for hc 20..39, vc 20..39. Updates exactly at hc=20; neighbouring cells remain 0.
- **Slot collision.** wr_valid held from hc=18, vc=0 → wr_ready=0 and mem_addr=1, mem_we=0 at hc=18. Write accepted at hc=19.
- **Wrap.** hc=798, vc=524 → mem_addr=0 fetch. hc=798, vc=479 → no fetch, wr_ready=1.
- **Out-of-range write.** wr_addr=800 → accepted, mem_we=0, wr_err=1 for one cycle.
- **Fill (macro on).** clr_req with clr_color=0x1C → clr_busy high and wr_ready=0 throughout. clr_done after 768 writes plus the stalled slots. Every cell then reads 0x1C. Reset issued mid-fill → IDLE with no clr_done.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer path.
// Holds the 640x480@60 timing figures, the framebuffer cell geometry defaults,
// the fill FSM state type and a small cell-index helper.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned HPIXELS = 640;
  localparam int unsigned HFP     = 16;
  localparam int unsigned HSPULSE = 96;
  localparam int unsigned HBP     = 48;
  localparam int unsigned HTOTAL_DEF = HPIXELS + HFP + HSPULSE + HBP;

  // Vertical timing, in lines
  localparam int unsigned VPIXELS = 480;
  localparam int unsigned VFP     = 10;
  localparam int unsigned VSPULSE = 2;
  localparam int unsigned VBP     = 33;
  localparam int unsigned VTOTAL_DEF = VPIXELS + VFP + VSPULSE + VBP;

  // Framebuffer geometry: one color byte per square cell
  localparam int unsigned DEF_CELL_PX = 20;
  localparam int unsigned DEF_COLS    = 32;
  localparam int unsigned DEF_ROWS    = 24;
  localparam int unsigned FB_DEPTH    = DEF_COLS * DEF_ROWS;

  // Fill engine states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // Linear RAM index of a cell, row-major
  function automatic int unsigned cell_index(input int unsigned row, input int unsigned col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/vga_fb_slot.sv
// Display-slot decoder for the framebuffer arbiter.
// Purely combinational: from the beam counters it decides whether this cycle
// belongs to a display read and, if so, which cell must be fetched. The fetch
// runs two pixels ahead of the beam so the color is registered exactly at the
// first pixel of each cell. The first cell of every line is fetched at the end
// of the previous line (including the frame wrap back to row 0).
module vga_fb_slot
  import vga_pkg::*;
#(
  parameter int unsigned CELL_PX = DEF_CELL_PX,
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned HTOTAL  = HTOTAL_DEF,
  parameter int unsigned VTOTAL  = VTOTAL_DEF
) (
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic       slot,
  output logic [9:0] slot_addr
);

  localparam int unsigned ActiveW = COLS * CELL_PX;
  localparam int unsigned ActiveH = ROWS * CELL_PX;

  int unsigned hc_u;
  int unsigned vc_u;
  int unsigned nv_u;
  logic        cell_slot;
  logic        line_slot;

  // Decode both fetch cases and pick the matching cell address
  always_comb begin
    hc_u = 32'(hc);
    vc_u = 32'(vc);
    nv_u = (vc_u == VTOTAL - 1) ? 32'd0 : vc_u + 32'd1;

    // Mid-line: two pixels before the next cell start, last cell excluded
    // because its successor is the first cell of the next line.
    cell_slot = ((hc_u % CELL_PX) == CELL_PX - 2) && (hc_u + 2 < ActiveW) && (vc_u < ActiveH);
    // End of line: prefetch column 0 of the upcoming visible line
    line_slot = (hc_u == HTOTAL - 2) && (nv_u < ActiveH);

    slot      = cell_slot | line_slot;
    slot_addr = '0;
    if (cell_slot) begin
      slot_addr = 10'(cell_index(vc_u / CELL_PX, (hc_u + 2) / CELL_PX, COLS));
    end else if (line_slot) begin
      slot_addr = 10'(cell_index(nv_u / CELL_PX, 0, COLS));
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer access controller between the VGA timing generator and a
// single-port color RAM with one-cycle synchronous read.
// Owners of the RAM port, highest first: display prefetch, fill engine, writer.
// Optional feature: define VGA_FB_CLEAR_EN to build the whole-framebuffer fill
// engine; without it clr_req/clr_color are ignored and clr_busy/clr_done stay 0.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned CELL_PX = DEF_CELL_PX,
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned HTOTAL  = HTOTAL_DEF,
  parameter int unsigned VTOTAL  = VTOTAL_DEF
) (
  input  logic       vgaclk,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic [7:0] colorPacking,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_err,
  input  logic       clr_req,
  input  logic [7:0] clr_color,
  output logic       clr_busy,
  output logic       clr_done,
  output logic [9:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int unsigned Depth    = COLS * ROWS;
  localparam logic [9:0]  LastAddr = 10'(Depth - 1);

  logic       slot;
  logic [9:0] slot_addr;

  vga_fb_slot #(
    .CELL_PX(CELL_PX),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .HTOTAL (HTOTAL),
    .VTOTAL (VTOTAL)
  ) u_slot (
    .hc       (hc),
    .vc       (vc),
    .slot     (slot),
    .slot_addr(slot_addr)
  );

  fb_state_t  state_q;
  logic [9:0] clr_addr_q;
  logic [7:0] clr_color_q;

  logic       pending_q, pending_d;
  logic [7:0] color_q, color_d;
  logic       wr_err_q, wr_err_d;

  logic       wr_fire;
  logic       wr_oor;
  logic       clr_write;

  // Writer handshake: only free cycles with the fill engine idle are offered
  always_comb begin
    wr_ready  = !slot && (state_q == IDLE) && rst_n;
    wr_fire   = wr_valid && wr_ready;
    wr_oor    = 32'(wr_addr) >= Depth;
    clr_write = (state_q == CLEAR) && !slot;
  end

  // RAM port mux; an out-of-range write still presents its address but never writes
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (slot) begin
        mem_addr = slot_addr;
      end else if (clr_write) begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = clr_color_q;
      end else if (wr_fire) begin
        mem_we    = !wr_oor;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  // Fetch pipeline: slot cycle -> RAM read cycle -> color register
  always_comb begin
    pending_d = slot;
    color_d   = pending_q ? mem_rdata : color_q;
    wr_err_d  = wr_fire && wr_oor;
  end

  // Pipeline and error flops
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      color_q   <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      color_q   <= color_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign colorPacking = color_q;
  assign wr_err       = wr_err_q;

`ifdef VGA_FB_CLEAR_EN
  fb_state_t  state_d;
  logic [9:0] clr_addr_d;
  logic [7:0] clr_color_d;
  logic       clr_done_q, clr_done_d;

  // Fill engine: walk every cell once, yielding to display slots
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    clr_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clr_color;
        end
      end
      CLEAR: begin
        if (!slot) begin
          if (clr_addr_q == LastAddr) begin
            state_d    = IDLE;
            clr_addr_d = '0;
            clr_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill engine state; a reset mid-fill abandons the walk without clr_done
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      clr_done_q  <= clr_done_d;
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = clr_done_q;
`else
  logic unused_clr;

  assign state_q     = IDLE;
  assign clr_addr_q  = '0;
  assign clr_color_q = '0;
  assign clr_busy    = 1'b0;
  assign clr_done    = 1'b0;
  assign unused_clr  = ^{clr_req, clr_color};
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter at default geometry. The bench plays both the
// timing generator (it drives hc/vc freely, jumping to the lines of interest)
// and the synchronous RAM. Expected colors come from a shadow framebuffer and
// the rule "a cell is fetched when the beam position two pixels ahead is the
// first pixel of a visible cell".
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int unsigned CellPx = 20;
  localparam int unsigned Cols   = 32;
  localparam int unsigned Rows   = 24;
  localparam int unsigned HTot   = 800;
  localparam int unsigned VTot   = 525;
  localparam int unsigned Depth  = FB_DEPTH;

  logic       vgaclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic [7:0] colorPacking;
  logic       wr_valid = 1'b0, wr_ready;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_err;
  logic       clr_req = 1'b0;
  logic [7:0] clr_color = '0;
  logic       clr_busy, clr_done;
  logic [9:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram    [0:1023] = '{default: 8'h00};
  logic [7:0] shadow [0:Depth-1];

  int total = 0;
  int bad   = 0;

  vga_fb_arbiter #(
    .CELL_PX(CellPx),
    .COLS   (Cols),
    .ROWS   (Rows),
    .HTOTAL (HTot),
    .VTOTAL (VTot)
  ) dut (
    .vgaclk      (vgaclk),
    .rst_n       (rst_n),
    .hc          (hc),
    .vc          (vc),
    .colorPacking(colorPacking),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .clr_req     (clr_req),
    .clr_color   (clr_color),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 vgaclk = ~vgaclk;

  // Single-port RAM, one-cycle synchronous read
  always @(posedge vgaclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic advance();
    if (32'(hc) == HTot - 1) begin
      hc = '0;
      vc = (32'(vc) == VTot - 1) ? 10'd0 : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end
  endtask

  // Cell fetched in this cycle, or -1: look two pixels ahead of the beam
  function automatic int fetch_of(input int unsigned h, input int unsigned v);
    int unsigned h2 = h + 2;
    int unsigned v2 = v;
    if (h2 >= HTot) begin
      h2 -= HTot;
      v2 = (v == VTot - 1) ? 0 : v + 1;
    end
    if ((h2 % CellPx) == 0 && h2 < Cols * CellPx && v2 < Rows * CellPx)
      return int'((v2 / CellPx) * Cols + h2 / CellPx);
    return -1;
  endfunction

  // Display one whole visible line v (plus the prefetch at the end of the line before)
  task automatic run_line(input int unsigned v);
    int unsigned col;
    vc = 10'((v == 0) ? VTot - 1 : v - 1);
    hc = 10'(HTot - 2);
    tick();
    hc = 10'(HTot - 1);
    tick();
    vc = 10'(v);
    for (int h = 0; h < int'(HTot); h++) begin
      hc = 10'(h);
      #1;
      col = (h < int'(Cols * CellPx)) ? h / CellPx : Cols - 1;
      check("pixel", 32'(colorPacking), 32'(shadow[(v / CellPx) * Cols + col]));
      tick();
    end
  endtask

  initial begin
    int          fa;
    int unsigned a;
    logic [7:0]  d;
    bit          done;
    int          writes;
    int          seen;

    for (int i = 0; i < int'(Depth); i++) shadow[i] = 8'h00;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      hc        = 10'($urandom_range(0, HTot - 1));
      vc        = 10'($urandom_range(0, VTot - 1));
      wr_valid  = 1'($urandom);
      wr_addr   = 10'($urandom);
      wr_data   = 8'($urandom);
      clr_req   = 1'($urandom);
      clr_color = 8'($urandom);
      #1;
      check("rst_color", 32'(colorPacking), 0);
      check("rst_wr_err", 32'(wr_err), 0);
      check("rst_busy", 32'(clr_busy), 0);
      check("rst_done", 32'(clr_done), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_ready", 32'(wr_ready), 0);
      tick();
    end
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    hc       = 10'd5;
    vc       = 10'd0;
    rst_n    = 1'b1;
    #1;
    check("ready_after_rst", 32'(wr_ready), 1);
    tick();

    // Directed write to cell 33 during vertical blanking, then display around it
    hc = 10'd100; vc = 10'd500;
    wr_valid = 1'b1; wr_addr = 10'd33; wr_data = 8'hA5;
    #1;
    check("w33_ready", 32'(wr_ready), 1);
    check("w33_we", 32'(mem_we), 1);
    check("w33_addr", 32'(mem_addr), 33);
    check("w33_wdata", 32'(mem_wdata), 32'hA5);
    shadow[33] = 8'hA5;
    tick();
    wr_valid = 1'b0;
    #1;
    check("w33_err", 32'(wr_err), 0);
    run_line(19);
    run_line(20);
    run_line(39);
    run_line(40);

    // Write request colliding with a display slot
    hc = 10'd18; vc = 10'd0;
    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 8'h3C;
    #1;
    check("coll_ready", 32'(wr_ready), 0);
    check("coll_addr", 32'(mem_addr), 1);
    check("coll_we", 32'(mem_we), 0);
    tick();
    hc = 10'd19;
    #1;
    check("coll_ready2", 32'(wr_ready), 1);
    check("coll_we2", 32'(mem_we), 1);
    check("coll_addr2", 32'(mem_addr), 5);
    shadow[5] = 8'h3C;
    tick();
    wr_valid = 1'b0;

    // Line and frame wrap prefetches
    hc = 10'd798; vc = 10'd524;
    #1;
    check("wrap_frame_ready", 32'(wr_ready), 0);
    check("wrap_frame_addr", 32'(mem_addr), 0);
    check("wrap_frame_we", 32'(mem_we), 0);
    vc = 10'd19;
    #1;
    check("wrap_line_addr", 32'(mem_addr), 32);
    check("wrap_line_ready", 32'(wr_ready), 0);
    vc = 10'd479;
    #1;
    check("wrap_last_ready", 32'(wr_ready), 1);
    check("wrap_last_addr", 32'(mem_addr), 0);
    tick();

    // Out-of-range write
    hc = 10'd5; vc = 10'd0;
    wr_valid = 1'b1; wr_addr = 10'd800; wr_data = 8'h77;
    #1;
    check("oor_ready", 32'(wr_ready), 1);
    check("oor_we", 32'(mem_we), 0);
    tick();
    wr_valid = 1'b0;
    #1;
    check("oor_err", 32'(wr_err), 1);
    tick();
    check("oor_err_clear", 32'(wr_err), 0);

    // Random writes at random beam positions
    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(Depth, 1023) : $urandom_range(0, Depth - 1);
      d = 8'($urandom);
      hc = 10'($urandom_range(0, HTot - 1));
      vc = 10'($urandom_range(0, VTot - 1));
      wr_valid = 1'b1; wr_addr = 10'(a); wr_data = d;
      done = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
        #1;
        fa = fetch_of(32'(hc), 32'(vc));
        if (fa >= 0) begin
          check("rnd_slot_ready", 32'(wr_ready), 0);
          check("rnd_slot_addr", 32'(mem_addr), 32'(fa));
          check("rnd_slot_we", 32'(mem_we), 0);
          tick();
          advance();
        end else begin
          check("rnd_ready", 32'(wr_ready), 1);
          check("rnd_we", 32'(mem_we), (a < Depth) ? 1 : 0);
          check("rnd_addr", 32'(mem_addr), a);
          if (a < Depth) begin
            check("rnd_wdata", 32'(mem_wdata), 32'(d));
            shadow[a] = d;
          end
          tick();
          wr_valid = 1'b0;
          check("rnd_err", 32'(wr_err), (a >= Depth) ? 1 : 0);
          done = 1'b1;
        end
      end
      check("rnd_accepted", 32'(done), 1);
      wr_valid = 1'b0;
    end

    // One random line from every cell row
    for (int r = 0; r < int'(Rows); r++) run_line(r * CellPx + $urandom_range(0, CellPx - 1));

`ifdef VGA_FB_CLEAR_EN
    // Full fill across active lines, writer held off throughout
    hc = 10'd0; vc = 10'd0;
    clr_color = 8'h1C; clr_req = 1'b1;
    #1;
    check("fill_busy_pre", 32'(clr_busy), 0);
    tick();
    clr_req = 1'b0; clr_color = 8'hFF;
    wr_valid = 1'b1; wr_addr = 10'd3; wr_data = 8'h99;
    writes = 0;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      #1;
      check("fill_busy", 32'(clr_busy), 1);
      check("fill_ready", 32'(wr_ready), 0);
      check("fill_done_early", 32'(clr_done), 0);
      if (fetch_of(32'(hc), 32'(vc)) < 0) writes++;
      tick();
      advance();
      if (writes == int'(Depth)) done = 1'b1;
    end
    wr_valid = 1'b0;
    check("fill_finished", 32'(done), 1);
    #1;
    check("fill_done", 32'(clr_done), 1);
    check("fill_busy_end", 32'(clr_busy), 0);
    tick();
    check("fill_done_pulse", 32'(clr_done), 0);
    seen = 0;
    for (int i = 0; i < int'(Depth); i++) if (ram[i] !== 8'h1C) seen++;
    check("fill_ram_cells", 32'(seen), 0);
    for (int i = 0; i < int'(Depth); i++) shadow[i] = 8'h1C;
    run_line(0);
    run_line(250);

    // Reset part-way through a second fill
    hc = 10'd640; vc = 10'd490;
    clr_color = 8'hE3; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      advance();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(clr_busy), 0);
    check("midrst_we", 32'(mem_we), 0);
    tick();
    rst_n = 1'b1;
    check("midrst_ram_lo", 32'(ram[99]), 32'hE3);
    check("midrst_ram_hi", 32'(ram[100]), 32'h1C);
    seen = 0;
    for (int k = 0; k < 900; k++) begin
      #1;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) seen++;
      tick();
      advance();
    end
    check("midrst_no_done", 32'(seen), 0);
`else
    // Fill requests have no effect in this build
    hc = 10'd0; vc = 10'd490;
    clr_color = 8'h1C; clr_req = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      check("noclr_busy", 32'(clr_busy), 0);
      check("noclr_done", 32'(clr_done), 0);
      check("noclr_ready", 32'(wr_ready), 1);
      check("noclr_we", 32'(mem_we), 0);
      tick();
      advance();
    end
    clr_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
